// File: rtl/fmps_readout_sequencer_pkg.sv
// Shared definitions for the FMPS readout path: sequencer state encoding,
// readout-check result codes and readout word field positions.
package fmps_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WAIT,
    ST_CHECK,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [2:0] ERR_OK     = 3'd0;
  localparam logic [2:0] ERR_FLAGS  = 3'd1;
  localparam logic [2:0] ERR_STATUS = 3'd2;
  localparam logic [2:0] ERR_ADDR   = 3'd3;
  localparam logic [2:0] ERR_MAGIC  = 3'd4;
  localparam logic [2:0] ERR_CYCLE  = 3'd5;

  localparam int unsigned FLAG_HI_BIT  = 31;
  localparam int unsigned FLAG_LO_BIT  = 30;
  localparam int unsigned STATUS_BIT   = 29;
  localparam int unsigned ADDR_MSB     = 28;
  localparam int unsigned ADDR_LSB     = 24;
  localparam int unsigned ADDR_FIELD_W = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned MAGIC_MSB    = 23;
  localparam int unsigned MAGIC_LSB    = 8;
  localparam int unsigned CYCLE_MSB    = 7;
  localparam int unsigned CYCLE_LSB    = 0;

endpackage

// File: rtl/fmps_readout_checker.sv
// Combinational field check of one FMPS readout word; returns the code of the
// highest-priority fault found, or ERR_OK.
module fmps_readout_checker
  import fmps_readout_sequencer_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 5,
  parameter logic [15:0] DATA_MAGIC  = 16'hCACA
) (
  input  logic [31:0]            readout,
  input  logic [7:0]             expectedCycle,
  input  logic [INDEX_WIDTH-1:0] address,
  output logic [2:0]             errCode
);

  logic [ADDR_FIELD_W-1:0] addrField;

  // Priority-ordered field checks: flags, status, address, magic, cycle.
  always_comb begin
    addrField = ADDR_FIELD_W'(address);
    errCode   = ERR_OK;
    if (readout[FLAG_HI_BIT] || readout[FLAG_LO_BIT])
      errCode = ERR_FLAGS;
    else if (readout[STATUS_BIT])
      errCode = ERR_STATUS;
    else if (readout[ADDR_MSB:ADDR_LSB] != addrField)
      errCode = ERR_ADDR;
    else if (readout[MAGIC_MSB:MAGIC_LSB] != DATA_MAGIC)
      errCode = ERR_MAGIC;
    else if (readout[CYCLE_MSB:CYCLE_LSB] != expectedCycle)
      errCode = ERR_CYCLE;
  end

endmodule

// File: rtl/fmps_readout_sequencer.sv
// Walks a snapshot of the FMPS packet-present bitmap, reads each present
// entry from the DPRAM, validates it and streams good words over AXI-Stream.
module fmps_readout_sequencer
  import fmps_readout_sequencer_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 5,
  parameter logic [15:0] DATA_MAGIC  = 16'hCACA
) (
  input  logic                        sysClk,
  input  logic                        sysReset_n,
  input  logic                        start,
  input  logic [7:0]                  expectedCycle,
  input  logic [2**INDEX_WIDTH-1:0]   fmpsBitmapAll,
  output logic [INDEX_WIDTH-1:0]      fmpsReadoutAddress,
  input  logic [31:0]                 fmpsReadout,
  output logic [31:0]                 m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic                        busy,
  output logic                        scanDone,
  output logic [INDEX_WIDTH:0]        wordCount,
  output logic [15:0]                 errorCount,
  output logic [2:0]                  firstErrCode,
  output logic [INDEX_WIDTH-1:0]      firstErrAddr,
  output logic                        overrun,
  input  logic                        clearErrors
);

  localparam int unsigned DEPTH = 2**INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] TOP_INDEX = '1;

  state_t                 state;
  logic [DEPTH-1:0]       snapshot;
  logic [2:0]             checkCode;
  logic                   atTop;
  logic [INDEX_WIDTH-1:0] nextAddr;
  logic [DEPTH-1:0]       aboveMask;
  logic                   lastBeat;

  fmps_readout_checker #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .DATA_MAGIC  (DATA_MAGIC)
  ) u_checker (
    .readout       (fmpsReadout),
    .expectedCycle (expectedCycle),
    .address       (fmpsReadoutAddress),
    .errCode       (checkCode)
  );

  // Address advance and end-of-stream detection for the current index.
  always_comb begin
    atTop     = (fmpsReadoutAddress == TOP_INDEX);
    nextAddr  = fmpsReadoutAddress + 1'b1;
    // Mask of indexes strictly above the current one; wraps to zero at the top.
    aboveMask = ~((DEPTH'(2) << fmpsReadoutAddress) - DEPTH'(1));
    lastBeat  = ((snapshot & aboveMask) == '0);
  end

  // Scan FSM with registered stream, status and error-bookkeeping outputs.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state              <= ST_IDLE;
      snapshot           <= '0;
      fmpsReadoutAddress <= '0;
      m_tdata            <= '0;
      m_tvalid           <= 1'b0;
      m_tlast            <= 1'b0;
      busy               <= 1'b0;
      scanDone           <= 1'b0;
      wordCount          <= '0;
      errorCount         <= '0;
      firstErrCode       <= ERR_OK;
      firstErrAddr       <= '0;
      overrun            <= 1'b0;
    end else begin
      scanDone <= 1'b0;

      // Clear first; an error or overrun in the same cycle is applied after it.
      if (clearErrors) begin
        errorCount   <= '0;
        firstErrCode <= ERR_OK;
        firstErrAddr <= '0;
        overrun      <= 1'b0;
      end
      if (start && state != ST_IDLE)
        overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            snapshot           <= fmpsBitmapAll;
            fmpsReadoutAddress <= '0;
            wordCount          <= '0;
            busy               <= 1'b1;
            state              <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (snapshot == '0 || (!snapshot[fmpsReadoutAddress] && atTop)) begin
            busy     <= 1'b0;
            scanDone <= 1'b1;
            state    <= ST_DONE;
          end else if (snapshot[fmpsReadoutAddress]) begin
            state <= ST_WAIT;
          end else begin
            fmpsReadoutAddress <= nextAddr;
          end
        end

        ST_WAIT: state <= ST_CHECK;

        ST_CHECK: begin
          if (checkCode == ERR_OK) begin
            m_tdata  <= fmpsReadout;
            m_tlast  <= lastBeat;
            m_tvalid <= 1'b1;
            state    <= ST_SEND;
          end else begin
            if (clearErrors) begin
              errorCount   <= 16'd1;
              firstErrCode <= checkCode;
              firstErrAddr <= fmpsReadoutAddress;
            end else begin
              if (errorCount != '1)
                errorCount <= errorCount + 16'd1;
              if (firstErrCode == ERR_OK) begin
                firstErrCode <= checkCode;
                firstErrAddr <= fmpsReadoutAddress;
              end
            end
            if (atTop) begin
              busy     <= 1'b0;
              scanDone <= 1'b1;
              state    <= ST_DONE;
            end else begin
              fmpsReadoutAddress <= nextAddr;
              state              <= ST_SCAN;
            end
          end
        end

        ST_SEND: begin
          if (m_tready) begin
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            wordCount <= wordCount + 1'b1;
            if (atTop) begin
              busy     <= 1'b0;
              scanDone <= 1'b1;
              state    <= ST_DONE;
            end else begin
              fmpsReadoutAddress <= nextAddr;
              state              <= ST_SCAN;
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
